// File: rtl/box_drawer.sv
// -----------------------------------------------------------------------------
// box_drawer
//
// Rasterises one axis-aligned filled rectangle per accepted request into a
// stream of single-pixel writes, one pixel per clock in row-major order.
// Pixels that fall off the right or bottom edge of the screen still take
// their cycle but are not plotted.
//
// Parameters:
//   SCREEN_WIDTH   visible columns; columns >= SCREEN_WIDTH are not plotted
//   SCREEN_HEIGHT  visible rows;    rows    >= SCREEN_HEIGHT are not plotted
//
// Ports:
//   clock         system clock, rising-edge active
//   reset_n       asynchronous active-low reset
//   s_valid       box request present
//   s_ready       block idle and able to accept a request
//   in_box_x/y    top-left corner of the box
//   in_box_w/h    box size in pixels (0 = empty box)
//   in_box_color  fill colour
//   vga_x/y       coordinates of the current pixel
//   vga_color     colour of the current pixel
//   vga_plot      write strobe for the current pixel
//   box_done      one-cycle pulse when a box has completed
// -----------------------------------------------------------------------------
module box_drawer #(
    parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
    parameter logic [8:0] SCREEN_HEIGHT = 9'd240
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [8:0] in_box_x,
    input  logic [8:0] in_box_y,
    input  logic [8:0] in_box_w,
    input  logic [8:0] in_box_h,
    input  logic [2:0] in_box_color,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_color,
    output logic       vga_plot,
    output logic       box_done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [8:0] r_x;
    logic [8:0] r_y;
    logic [8:0] r_w;
    logic [8:0] r_h;
    logic [2:0] r_color;
    logic [8:0] r_col;
    logic [8:0] r_row;
    logic       r_box_done;

    logic       w_accept;
    logic       w_empty;
    logic       w_last_col;
    logic       w_last_row;
    logic       w_last_pixel;
    logic [9:0] w_col_sum;
    logic [9:0] w_row_sum;

    assign w_accept     = s_valid && (r_state == S_IDLE);
    assign w_empty      = (in_box_w == 9'd0) || (in_box_h == 9'd0);
    // Only meaningful in S_DRAW, where the latched w and h are both >= 1.
    assign w_last_col   = (r_col == (r_w - 9'd1));
    assign w_last_row   = (r_row == (r_h - 9'd1));
    assign w_last_pixel = w_last_col && w_last_row;
    // Sums are one bit wider than the operands so they cannot wrap back
    // on-screen; the extra bit makes far-right/bottom pixels clip correctly.
    assign w_col_sum    = {1'b0, r_x} + {1'b0, r_col};
    assign w_row_sum    = {1'b0, r_y} + {1'b0, r_row};

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: empty boxes complete without leaving S_IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_empty) begin
                    w_next_state = S_DRAW;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_DRAW: begin
                if (w_last_pixel) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DRAW;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request latch, column/row scan counters and the done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x        <= 9'd0;
            r_y        <= 9'd0;
            r_w        <= 9'd0;
            r_h        <= 9'd0;
            r_color    <= 3'd0;
            r_col      <= 9'd0;
            r_row      <= 9'd0;
            r_box_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x     <= in_box_x;
                r_y     <= in_box_y;
                r_w     <= in_box_w;
                r_h     <= in_box_h;
                r_color <= in_box_color;
                r_col   <= 9'd0;
                r_row   <= 9'd0;
            end else if (r_state == S_DRAW) begin
                if (w_last_col) begin
                    r_col <= 9'd0;
                    r_row <= r_row + 9'd1;
                end else begin
                    r_col <= r_col + 9'd1;
                end
            end
            r_box_done <= (w_accept && w_empty) ||
                          ((r_state == S_DRAW) && w_last_pixel);
        end
    end

    // Pixel outputs decoded from registered state; plot only on-screen pixels.
    always_comb begin
        s_ready   = 1'b0;
        vga_plot  = 1'b0;
        vga_x     = w_col_sum[8:0];
        vga_y     = w_row_sum[7:0];
        vga_color = r_color;
        box_done  = r_box_done;
        if (r_state == S_IDLE) begin
            s_ready  = 1'b1;
            vga_plot = 1'b0;
        end else begin
            s_ready  = 1'b0;
            vga_plot = (w_col_sum < {1'b0, SCREEN_WIDTH}) &&
                       (w_row_sum < {1'b0, SCREEN_HEIGHT});
        end
    end

endmodule

// File: tb/tb_box_drawer.sv
module tb_box_drawer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       s_valid;
    logic       s_ready;
    logic [8:0] in_box_x;
    logic [8:0] in_box_y;
    logic [8:0] in_box_w;
    logic [8:0] in_box_h;
    logic [2:0] in_box_color;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_color;
    logic       vga_plot;
    logic       box_done;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    box_drawer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .in_box_x     (in_box_x),
        .in_box_y     (in_box_y),
        .in_box_w     (in_box_w),
        .in_box_h     (in_box_h),
        .in_box_color (in_box_color),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_color    (vga_color),
        .vga_plot     (vga_plot),
        .box_done     (box_done)
    );

    always #5 clock = ~clock;

    // Reference model: expected on-screen pixels of a box, row-major.
    task automatic push_box(input int x, input int y, input int w, input int h, input int c);
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                int   sx;
                int   sy;
                pix_t p;
                sx = x + k;
                sy = y + r;
                if (sx < 320 && sy < 240) begin
                    p.x = sx[8:0];
                    p.y = sy[7:0];
                    p.c = c[2:0];
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic drive_req(input int x, input int y, input int w, input int h, input int c);
        in_box_x     = x[8:0];
        in_box_y     = y[8:0];
        in_box_w     = w[8:0];
        in_box_h     = h[8:0];
        in_box_color = c[2:0];
        s_valid      = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s_valid = 1'b0;
        drive_req(0, 0, 0, 0, 0);
        s_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (s_ready !== 1'b1 || vga_plot !== 1'b0 || box_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b plot=%b done=%b, want 1 0 0", s_ready, vga_plot, box_done);
        end
        checks++;
        if (vga_x !== 9'd0 || vga_y !== 8'd0 || vga_color !== 3'd0) begin
            errors++;
            $display("FAIL reset_pix: x=%0d y=%0d c=%0d, want 0 0 0", vga_x, vga_y, vga_color);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1 || vga_plot !== 1'b0 || box_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: ready=%b plot=%b done=%b, want 1 0 0", s_ready, vga_plot, box_done);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int   done_cyc;
        int   draw_cyc;
        pix_t p;
        @(negedge clock);
        drive_req(5, 7, 2, 3, 5);
        push_box(5, 7, 2, 3, 5);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b want 1", s_ready);
        end
        done_cyc = 0;
        draw_cyc = 0;
        for (int n = 1; n <= 50 && done_cyc == 0; n++) begin
            @(negedge clock);
            if (s_ready === 1'b0) draw_cyc++;
            if (vga_plot === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL basic_pix: unexpected plot at (%0d,%0d)", vga_x, vga_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({vga_x, vga_y, vga_color} !== p) begin
                        errors++;
                        $display("FAIL basic_pix: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                 vga_x, vga_y, vga_color, p.x, p.y, p.c);
                    end
                end
            end
            if (box_done === 1'b1) begin
                done_cyc = n;
                checks++;
                if (s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_done_ready: got %b want 1", s_ready);
                end
            end
            if (n == 1) s_valid = 1'b0;
        end
        checks++;
        if (done_cyc != 7) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d want 7", done_cyc);
        end
        checks++;
        if (draw_cyc != 6) begin
            errors++;
            $display("FAIL basic_draw_cycles: got %0d want 6", draw_cyc);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_missing: %0d pixels not plotted, want 0", exp_q.size());
        end
        exp_q.delete();
        @(negedge clock);
        checks++;
        if (box_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: got %b want 0", box_done);
        end
    endtask

    task automatic test_empty();
        @(negedge clock);
        drive_req(10, 10, 0, 4, 3);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_ready0: got %b want 1", s_ready);
        end
        @(negedge clock);
        checks++;
        if (box_done !== 1'b1 || s_ready !== 1'b1 || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL empty_done1: done=%b ready=%b plot=%b, want 1 1 0", box_done, s_ready, vga_plot);
        end
        drive_req(20, 20, 5, 0, 1);
        @(negedge clock);
        checks++;
        if (box_done !== 1'b1 || s_ready !== 1'b1 || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL empty_done2: done=%b ready=%b plot=%b, want 1 1 0", box_done, s_ready, vga_plot);
        end
        s_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (box_done !== 1'b0 || s_ready !== 1'b1 || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL empty_after: done=%b ready=%b plot=%b, want 0 1 0", box_done, s_ready, vga_plot);
        end
    endtask

    task automatic test_clip();
        int         done_cyc;
        int         draw_cyc;
        int         plots;
        int         ex;
        int         ey;
        pix_t       p;
        @(negedge clock);
        drive_req(318, 239, 4, 2, 7);
        push_box(318, 239, 4, 2, 7);
        done_cyc = 0;
        draw_cyc = 0;
        plots    = 0;
        for (int n = 1; n <= 40 && done_cyc == 0; n++) begin
            @(negedge clock);
            if (s_ready === 1'b0) begin
                draw_cyc++;
                ex = 318 + ((n - 1) % 4);
                ey = 239 + ((n - 1) / 4);
                checks++;
                if (vga_x !== ex[8:0] || vga_y !== ey[7:0]) begin
                    errors++;
                    $display("FAIL clip_coord: cycle %0d got (%0d,%0d) want (%0d,%0d)",
                             n, vga_x, vga_y, ex[8:0], ey[7:0]);
                end
            end
            if (vga_plot === 1'b1) begin
                plots++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL clip_pix: unexpected plot at (%0d,%0d)", vga_x, vga_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({vga_x, vga_y, vga_color} !== p) begin
                        errors++;
                        $display("FAIL clip_pix: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                 vga_x, vga_y, vga_color, p.x, p.y, p.c);
                    end
                end
            end
            if (box_done === 1'b1) done_cyc = n;
            if (n == 1) s_valid = 1'b0;
        end
        checks++;
        if (done_cyc != 9 || draw_cyc != 8) begin
            errors++;
            $display("FAIL clip_timing: done at %0d after %0d draw cycles, want 9 and 8", done_cyc, draw_cyc);
        end
        checks++;
        if (plots != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL clip_count: %0d plots, %0d left, want 2 and 0", plots, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int   done_cyc;
        int   plots;
        pix_t p;
        @(negedge clock);
        drive_req(0, 0, 320, 240, 1);
        push_box(0, 0, 320, 240, 1);
        done_cyc = 0;
        plots    = 0;
        for (int n = 1; n <= 77000 && done_cyc == 0; n++) begin
            @(negedge clock);
            if (vga_plot === 1'b1) begin
                plots++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_screen_pix: unexpected plot at (%0d,%0d)", vga_x, vga_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({vga_x, vga_y, vga_color} !== p) begin
                        errors++;
                        $display("FAIL b2b_screen_pix: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                 vga_x, vga_y, vga_color, p.x, p.y, p.c);
                    end
                end
            end
            if (box_done === 1'b1) begin
                done_cyc = n;
                checks++;
                if (vga_plot !== 1'b0 || s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gap: plot=%b ready=%b, want 0 1", vga_plot, s_ready);
                end
                drive_req(0, 100, 10, 48, 4);
            end
        end
        checks++;
        if (done_cyc != 76801 || plots != 76800) begin
            errors++;
            $display("FAIL b2b_screen: done at %0d with %0d plots, want 76801 and 76800", done_cyc, plots);
        end
        exp_q.delete();
        push_box(0, 100, 10, 48, 4);
        done_cyc = 0;
        plots    = 0;
        for (int n = 1; n <= 600 && done_cyc == 0; n++) begin
            @(negedge clock);
            if (n == 1) begin
                checks++;
                if (vga_plot !== 1'b1 || vga_x !== 9'd0 || vga_y !== 8'd100) begin
                    errors++;
                    $display("FAIL b2b_first: plot=%b at (%0d,%0d), want 1 at (0,100)", vga_plot, vga_x, vga_y);
                end
            end
            if (vga_plot === 1'b1) begin
                plots++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_paddle_pix: unexpected plot at (%0d,%0d)", vga_x, vga_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({vga_x, vga_y, vga_color} !== p) begin
                        errors++;
                        $display("FAIL b2b_paddle_pix: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                 vga_x, vga_y, vga_color, p.x, p.y, p.c);
                    end
                end
            end
            if (box_done === 1'b1) done_cyc = n;
            if (n == 1) s_valid = 1'b0;
        end
        checks++;
        if (done_cyc != 481 || plots != 480) begin
            errors++;
            $display("FAIL b2b_paddle: done at %0d with %0d plots, want 481 and 480", done_cyc, plots);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_draw();
        int   done_cyc;
        int   plots;
        int   spurious;
        pix_t p;
        @(negedge clock);
        drive_req(0, 100, 10, 48, 2);
        push_box(0, 100, 10, 48, 2);
        plots    = 0;
        spurious = 0;
        for (int n = 1; n <= 200 && plots < 100; n++) begin
            @(negedge clock);
            if (box_done === 1'b1) spurious++;
            if (vga_plot === 1'b1) begin
                plots++;
                checks++;
                p = exp_q.pop_front();
                if ({vga_x, vga_y, vga_color} !== p) begin
                    errors++;
                    $display("FAIL rmid_pix: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                             vga_x, vga_y, vga_color, p.x, p.y, p.c);
                end
            end
            if (n == 1) s_valid = 1'b0;
        end
        checks++;
        if (plots != 100) begin
            errors++;
            $display("FAIL rmid_progress: got %0d plots want 100", plots);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (vga_plot !== 1'b0 || s_ready !== 1'b1 || box_done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset: plot=%b ready=%b done=%b, want 0 1 0", vga_plot, s_ready, box_done);
        end
        checks++;
        if (vga_x !== 9'd0 || vga_y !== 8'd0 || vga_color !== 3'd0) begin
            errors++;
            $display("FAIL rmid_reset_pix: x=%0d y=%0d c=%0d, want 0 0 0", vga_x, vga_y, vga_color);
        end
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (box_done === 1'b1 || vga_plot === 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_abandon: %0d stray done/plot cycles, ready=%b, want 0 and 1", spurious, s_ready);
        end
        drive_req(20, 30, 3, 2, 6);
        push_box(20, 30, 3, 2, 6);
        done_cyc = 0;
        for (int n = 1; n <= 50 && done_cyc == 0; n++) begin
            @(negedge clock);
            if (vga_plot === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rmid_new_pix: unexpected plot at (%0d,%0d)", vga_x, vga_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({vga_x, vga_y, vga_color} !== p) begin
                        errors++;
                        $display("FAIL rmid_new_pix: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                 vga_x, vga_y, vga_color, p.x, p.y, p.c);
                    end
                end
            end
            if (box_done === 1'b1) done_cyc = n;
            if (n == 1) s_valid = 1'b0;
        end
        checks++;
        if (done_cyc != 7 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rmid_new_done: done at %0d with %0d left, want 7 and 0", done_cyc, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_clip();
        test_back_to_back();
        test_reset_mid_draw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/box_drawer.md
# box_drawer

Rasterises one axis-aligned filled rectangle per request into single-pixel writes for the VGA frame-buffer adapter. It sits directly downstream of the screen drawer: its slave port consumes the screen drawer's box requests (x, y, w, h, colour under a valid/ready handshake). Its master port drives the adapter's plot interface at one pixel per clock, in row-major order, and clips to the screen.

## Interface
Parameters:
- SCREEN_WIDTH, 9'd320, visible columns; pixels with x >= SCREEN_WIDTH are suppressed.
- SCREEN_HEIGHT, 9'd240, visible rows; pixels with y >= SCREEN_HEIGHT are suppressed.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  a box request is present.
- s_ready  output  1  the block can accept a request; combinational, high exactly in S_IDLE.
- in_box_x  input  9  left column.
- in_box_y  input  9  top row.
- in_box_w  input  9  width in pixels; 0 means empty.
- in_box_h  input  9  height in pixels; 0 means empty.
- in_box_color  input  3  fill colour.
- vga_x  output  9  column of the current pixel.
- vga_y  output  8  row of the current pixel (low 8 bits of the row sum).
- vga_color  output  3  colour of the current pixel.
- vga_plot  output  1  write strobe for the current pixel.
- box_done  output  1  one-cycle pulse after the last pixel of a box, or after an empty box is accepted.

## Operation
- States:
  - S_IDLE: s_ready = 1.
  - S_DRAW: s_ready = 0.
- Acceptance: s_valid && s_ready at a rising edge. On that edge:
  - Latch x, y, w, h and colour into internal registers.
  - Clear the col and row counters to 0.
- Transition out of S_IDLE on acceptance:
  - w == 0 or h == 0: stay in S_IDLE and pulse box_done.
  - Otherwise: move to S_DRAW.
- In S_DRAW, per cycle:
  - Column sum = latched x + col; row sum = latched y + row. Both are computed at 10 bits and can never wrap.
  - vga_x = column sum [8:0]; vga_y = row sum [7:0]; vga_color = latched colour.
  - vga_plot = 1 only when column sum < SCREEN_WIDTH and row sum < SCREEN_HEIGHT.
- Counter advance at each edge in S_DRAW:
  - col < w-1: col++.
  - Otherwise: col = 0 and row++.
  - When col == w-1 and row == h-1: go to S_IDLE and set box_done for the next cycle.
- Clipped pixels still consume their cycle. Every box takes exactly w*h S_DRAW cycles; for example, the 320x240 background takes 76800.
- In S_IDLE, vga_plot = 0. vga_x, vga_y and vga_color are don't-care but must not toggle plot.
- Inputs are ignored except at acceptance. Changing them mid-draw has no effect.
- Counters are 9 bits; h and w are at most 511, so the counters never overflow.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-draw):
  - State = S_IDLE; s_ready = 1; vga_plot = 0; box_done = 0.
  - vga_x = 0, vga_y = 0, vga_color = 0.
  - All latched registers and counters = 0.
  - Any partial box is abandoned with no box_done.
- Latency: if acceptance happens at edge E0, the first pixel is presented during the cycle after E0, and pixel n is presented in cycle n+1.
- The last pixel occupies cycle w*h. box_done and s_ready are high during cycle w*h+1.
- Back-to-back requests: with s_valid held high, the next box is accepted at the edge ending cycle w*h+1, giving one idle cycle between boxes.
- Empty box accepted at E0: box_done is high in cycle 1 and s_ready stays high, so a new request can be accepted at E1.
- box_done is registered and lasts exactly one cycle.

## Test plan
- Reset: assert reset_n=0 asynchronously mid-cycle -> immediately s_ready=1, vga_plot=0, box_done=0.
- Basic box: x=5, y=7, w=2, h=3, colour=5 -> six plot cycles at (5,7), (6,7), (5,8), (6,8), (5,9), (6,9), all with colour 5, then box_done=1 for one cycle together with s_ready=1.
- Empty box: w=0, h=4 -> accepted; vga_plot never rises; box_done high the next cycle; s_ready never drops.
- Clipping: x=318, y=239, w=4, h=2 -> eight S_DRAW cycles; plot high only at (318,239) and (319,239).
- Back-to-back: full-screen request (x=0, y=0, w=320, h=240) followed by a 10x48 paddle at (0,100), with s_valid held -> exactly 76800 pixels, box_done, a one-cycle gap, then 480 paddle pixels starting at (0,100).
- Reset mid-draw: pull reset_n low after 100 pixels of a 10x48 box -> plot drops at once; no box_done; after release s_ready=1 and a new box draws from its own origin.
